// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built around one 4x4 multiplier.
package mul8_seq_pkg;

   localparam int OP_W      = 8;
   localparam int PROD_W    = 16;
   localparam int NUM_STEPS = 4;
   localparam int NIB_W     = 4;
   localparam int STEP_W    = $clog2(NUM_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Left shift of each partial product: step 0 -> 0, steps 1/2 -> 4, step 3 -> 8.
   function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
      return {step[1] & step[0], step[1] ^ step[0], 2'b00};
   endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Request/result bundle of the sequential multiplier: operands and start in, busy/done/product out.
interface mul8_seq_ctrl_if;
   import mul8_seq_pkg::*;

   logic              start;
   logic [OP_W-1:0]   a;
   logic [OP_W-1:0]   b;
   logic              busy;
   logic              done;
   logic [PROD_W-1:0] p;

   modport master (output start, a, b, input busy, done, p);
   modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/mul8_seq_ctrl_mul4x4.sv
// Purely combinational 4x4 unsigned multiplier; the only multiplier in the block.
module mul4x4
   import mul8_seq_pkg::*;
(
   input  logic [NIB_W-1:0]   i_x,
   input  logic [NIB_W-1:0]   i_y,
   output logic [2*NIB_W-1:0] o_p
);

   assign o_p = (2*NIB_W)'(i_x) * (2*NIB_W)'(i_y);

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 multiplier: four nibble partial products accumulated over four CALC cycles.
// Optional zero-operand shortcut enabled by defining MUL8_SEQ_EARLY_OUT_EN.
module mul8_seq_ctrl
   import mul8_seq_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   mul8_seq_ctrl_if.slave bus
);

   state_e              r_state;
   state_e              w_state_next;
   logic [OP_W-1:0]     r_a;
   logic [OP_W-1:0]     r_b;
   logic [PROD_W-1:0]   r_acc;
   logic [PROD_W-1:0]   r_p;
   logic [STEP_W-1:0]   r_step;

   logic                w_accept;
   logic                w_zero_op;
   logic                w_last_step;
   logic [NIB_W-1:0]    w_nib_a;
   logic [NIB_W-1:0]    w_nib_b;
   logic [2*NIB_W-1:0]  w_pp;
   logic [PROD_W-1:0]   w_acc_next;
   logic                w_busy;
   logic                w_done;

   assign w_accept    = (r_state == IDLE) && bus.start;
   assign w_last_step = (r_step == STEP_W'(NUM_STEPS - 1));

`ifdef MUL8_SEQ_EARLY_OUT_EN
   assign w_zero_op = (bus.a == '0) || (bus.b == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   // Step bit 1 picks the high nibble of a, step bit 0 the high nibble of b.
   assign w_nib_a = r_step[1] ? r_a[OP_W-1:NIB_W] : r_a[NIB_W-1:0];
   assign w_nib_b = r_step[0] ? r_b[OP_W-1:NIB_W] : r_b[NIB_W-1:0];

   mul4x4 u_mul4x4 (
      .i_x (w_nib_a),
      .i_y (w_nib_b),
      .o_p (w_pp)
   );

   assign w_acc_next = r_acc + (PROD_W'(w_pp) << step_shift(r_step));

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // NOTE: default assignment first so no path through this block can infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_next = w_zero_op ? DONE : CALC;
         CALC:    if (w_last_step) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // p is written only when entering DONE, so partial sums never reach the output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_step <= '0;
         r_p    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a    <= bus.a;
                  r_b    <= bus.b;
                  r_acc  <= '0;
                  r_step <= '0;
                  if (w_zero_op) r_p <= '0;
               end
            end
            CALC: begin
               r_acc  <= w_acc_next;
               r_step <= r_step + 1'b1;
               if (w_last_step) r_p <= w_acc_next;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_busy = (r_state != IDLE);
      w_done = (r_state == DONE);
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.p    = r_p;

endmodule
